imem_arb: RTL
=============

IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 Parameter DW, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default `InstMemNum, number of DW-bit words.
REQ-003 Parameter AW, default `InstAddrWidth, byte-address width of both request ports.
REQ-004 Parameter MW, default DW/8, byte-write-mask width.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 f_req_valid  input  1  fetch channel read request.
REQ-008 f_req_ready  output  1  fetch request accepted this cycle when high with f_req_valid.
REQ-009 f_req_addr  input  AW  fetch byte address.
REQ-010 f_rsp_valid  output  1  fetch response available.
REQ-011 f_rsp_ready  input  1  fetch consumer takes response.
REQ-012 f_rsp_data  output  DW  fetched word.
REQ-013 f_rsp_err  output  1  address out of range.
REQ-014 l_req_valid / l_req_ready / l_req_addr  in/out/in  1/1/AW  loader (debug/boot) channel request.
REQ-015 l_req_we  input  1  1 = write, 0 = read.
REQ-016 l_req_wem  input  MW  byte-lane write mask.
REQ-017 l_req_wdata  input  DW  write data.
REQ-018 l_rsp_valid / l_rsp_ready / l_rsp_data / l_rsp_err  out/in/out/out  1/1/DW/1  loader response, same rules as fetch.

Function
REQ-019 Word index = addr[AW-1:2]; addr[1:0] SHALL be ignored.
REQ-020 Index >= DEPTH: no RAM access, no write; response returns data 0 and err=1 with normal latency.
REQ-021 Per channel FSM: IDLE (nothing outstanding), WAIT (access issued, RAM data next cycle), HOLD (data captured in channel skid register).
REQ-022 Channel eligible for grant in IDLE, or in WAIT/HOLD when its rsp_valid and rsp_ready are both high this cycle.
REQ-023 One RAM access per cycle; if both channels valid and eligible, round-robin: grant the channel not granted last contention; fetch wins the first contention after reset.
REQ-024 req_ready high only for the granted channel; ready SHALL NOT depend on its own rsp_ready except via REQ-022.
REQ-025 Read latency: request accepted at edge N -> rsp_valid high from cycle after edge N, data = RAM word at that edge.
REQ-026 If rsp_ready low while in WAIT, RAM output captured in skid register -> HOLD; rsp_data stable until handshake.
REQ-027 Loader write: masked lanes written at acceptance edge; response data 0, err 0, same latency; read-after-write to same word on next accepted request SHALL return new data.
REQ-028 Simultaneous loader write and fetch read same word: arbitration serialises; fetch sees old or new data per grant order, never mixed.
REQ-029 Back-to-back: channel with rsp_ready held high sustains one accepted request per cycle when uncontested.
REQ-030 Responses per channel SHALL return in request order; at most one outstanding per channel.

Reset
REQ-031 On rst: FSMs IDLE, rsp_valid 0, rsp_data 0, rsp_err 0, req_ready 0 while rst high, round-robin pointer = fetch.
REQ-032 Reset mid-access: in-flight responses dropped; writes accepted before reset edge retained; RAM contents not cleared.

Structure
REQ-033 `InstMemNum, `InstAddrWidth, `InstWidth, `InstBus SHALL come from defines.v; no new package constants beyond channel-id encoding (FETCH=0, LOAD=1).
REQ-034 Storage SHALL be one gnrl_ram instance (DP=DEPTH, AW, DW, MW, FORCE_X2ZERO=0); arbitration, FSMs, skid registers in imem_arb.

Verification
REQ-035 Preload via loader write addr 0x10 data 0xDEADBEEF wem 4'hF, then fetch 0x10 -> f_rsp_data 0xDEADBEEF one cycle after acceptance, err 0.
REQ-036 Loader write 0x20 wem 4'b0011 data 0x0000ABCD over 0x11223344 -> read returns 0x1122ABCD.
REQ-037 Both channels valid every cycle for 8 cycles, rsp_ready high -> grants alternate F,L,F,L..., 4 responses each.
REQ-038 Fetch accepted, f_rsp_ready low 5 cycles -> f_rsp_valid held, data stable, f_req_ready low, loader still served.
REQ-039 Fetch addr DEPTH*4 -> f_rsp_err 1, data 0; RAM unchanged for loader write out of range.
REQ-040 Assert rst during WAIT -> all rsp_valid 0 immediately; earlier write still readable after release.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-memory arbiter.
// Defines the channel ids and the per-channel response FSM states.
package imem_arb_pkg;

    typedef enum logic {
        CH_FETCH = 1'b0,
        CH_LOAD  = 1'b1
    } ch_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } ch_st_e;

    function automatic ch_e other_ch(input ch_e ch);
        return ch_e'(~ch);
    endfunction

endpackage

// File: rtl/gnrl_ram.sv
// Single-port byte-maskable RAM with registered read, inferred as block RAM.
// Out-of-range addresses never touch the array.
module gnrl_ram #(
    parameter int DP           = 256,
    parameter int AW           = 12,
    parameter int DW           = 32,
    parameter int MW           = 4,
    parameter int FORCE_X2ZERO = 0
) (
    input  logic          clk,
    input  logic          cs,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [MW-1:0] wem,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    localparam int IW = (DP > 1) ? $clog2(DP) : 1;
    localparam int LW = DW / MW;
    localparam logic [AW:0] DP_LIM = (AW+1)'(DP);

    logic [DW-1:0] mem [0:DP-1];
    logic [DW-1:0] dout_reg;
    logic          in_rng;
    logic [IW-1:0] idx;

    assign in_rng = ({1'b0, addr} < DP_LIM);
    assign idx    = addr[IW-1:0];

    always_ff @(posedge clk) begin
        if (cs && we && in_rng) begin
            for (int i = 0; i < MW; i++) begin
                if (wem[i]) begin
                    mem[idx][i*LW +: LW] <= din[i*LW +: LW];
                end
            end
        end
    end

    // An out-of-range read either leaves the output alone or, when asked, forces it to zero.
    always_ff @(posedge clk) begin
        if (cs && !we) begin
            if (in_rng) begin
                dout_reg <= mem[idx];
            end else if (FORCE_X2ZERO != 0) begin
                dout_reg <= '0;
            end
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/imem_arb.sv
// Instruction memory shared by a fetch read port and a loader read/write port.
// One RAM access per cycle, round-robin on contention, one outstanding response per channel.
`ifndef InstMemNum
`define InstMemNum 256
`endif
`ifndef InstAddrWidth
`define InstAddrWidth 12
`endif
`ifndef InstWidth
`define InstWidth 32
`endif
`ifndef InstBus
`define InstBus 31:0
`endif

module imem_arb
    import imem_arb_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = `InstMemNum,
    parameter int AW    = `InstAddrWidth,
    parameter int MW    = DW / 8
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          f_req_valid,
    output logic          f_req_ready,
    input  logic [AW-1:0] f_req_addr,
    output logic          f_rsp_valid,
    input  logic          f_rsp_ready,
    output logic [DW-1:0] f_rsp_data,
    output logic          f_rsp_err,

    input  logic          l_req_valid,
    output logic          l_req_ready,
    input  logic [AW-1:0] l_req_addr,
    input  logic          l_req_we,
    input  logic [MW-1:0] l_req_wem,
    input  logic [DW-1:0] l_req_wdata,
    output logic          l_rsp_valid,
    input  logic          l_rsp_ready,
    output logic [DW-1:0] l_rsp_data,
    output logic          l_rsp_err
);

    localparam int NCH = 2;
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    logic [NCH-1:0] req_valid;
    logic [NCH-1:0] req_we;
    logic [NCH-1:0] req_err;
    logic [NCH-1:0] rsp_ready;
    logic [NCH-1:0] rsp_valid;
    logic [NCH-1:0] rsp_err;
    logic [NCH-1:0] want;
    logic [NCH-1:0] grant;
    logic [NCH-1:0] accept;
    logic [AW-3:0]  req_idx  [NCH];
    logic [DW-1:0]  rsp_data [NCH];

    ch_e            rr_reg;
    ch_e            gnt_ch;
    logic           contend;

    logic           ram_cs;
    logic           ram_we;
    logic [AW-1:0]  ram_addr;
    logic [DW-1:0]  ram_dout;
    logic [AW-3:0]  acc_idx;

    // Byte offset within a word carries no meaning for whole-word accesses.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{f_req_addr[1:0], l_req_addr[1:0]};

    assign req_valid          = {l_req_valid, f_req_valid};
    assign rsp_ready          = {l_rsp_ready, f_rsp_ready};
    assign req_we             = {l_req_we, 1'b0};
    assign req_idx[CH_FETCH]  = f_req_addr[AW-1:2];
    assign req_idx[CH_LOAD]   = l_req_addr[AW-1:2];

    // Round-robin: rr_reg names the channel that wins the next contention.
    assign contend         = &want;
    assign grant[CH_FETCH] = want[CH_FETCH] & (~want[CH_LOAD]  | (rr_reg == CH_FETCH));
    assign grant[CH_LOAD]  = want[CH_LOAD]  & (~want[CH_FETCH] | (rr_reg == CH_LOAD));
    assign gnt_ch          = ch_e'(grant[CH_LOAD]);
    assign accept          = grant & {NCH{~rst}};

    assign f_req_ready = accept[CH_FETCH];
    assign l_req_ready = accept[CH_LOAD];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_reg <= CH_FETCH;
        end else if (contend) begin
            rr_reg <= other_ch(gnt_ch);
        end
    end

    assign acc_idx  = grant[CH_LOAD] ? req_idx[CH_LOAD] : req_idx[CH_FETCH];
    assign ram_cs   = (|accept) & ~(|(accept & req_err));
    assign ram_we   = grant[CH_LOAD] & l_req_we;
    assign ram_addr = {2'b00, acc_idx};

    gnrl_ram #(
        .DP           (DEPTH),
        .AW           (AW),
        .DW           (DW),
        .MW           (MW),
        .FORCE_X2ZERO (0)
    ) u_ram (
        .clk  (clk),
        .cs   (ram_cs),
        .we   (ram_we),
        .addr (ram_addr),
        .wem  (l_req_wem),
        .din  (l_req_wdata),
        .dout (ram_dout)
    );

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            ch_st_e        st_reg;
            ch_st_e        st_next;
            logic          zero_reg;
            logic          err_reg;
            logic [DW-1:0] skid_reg;
            logic [DW-1:0] wait_data;
            logic          rsp_hs;

            assign req_err[gi] = ({3'b000, req_idx[gi]} >= DEPTH_LIM);
            assign rsp_hs      = rsp_valid[gi] & rsp_ready[gi];
            assign want[gi]    = req_valid[gi] & ((st_reg == ST_IDLE) | rsp_hs);

            always_comb begin
                st_next = st_reg;
                if (accept[gi]) begin
                    st_next = ST_WAIT;
                end else begin
                    case (st_reg)
                        ST_WAIT: st_next = rsp_hs ? ST_IDLE : ST_HOLD;
                        ST_HOLD: st_next = rsp_hs ? ST_IDLE : ST_HOLD;
                        default: st_next = ST_IDLE;
                    endcase
                end
            end

            // RAM output is only ours during WAIT; freeze it before the other channel reuses the RAM.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    st_reg   <= ST_IDLE;
                    zero_reg <= 1'b0;
                    err_reg  <= 1'b0;
                    skid_reg <= '0;
                end else begin
                    st_reg <= st_next;
                    if (accept[gi]) begin
                        err_reg  <= req_err[gi];
                        zero_reg <= req_err[gi] | req_we[gi];
                    end
                    if (st_reg == ST_WAIT && st_next == ST_HOLD) begin
                        skid_reg <= wait_data;
                    end
                end
            end

            assign wait_data     = zero_reg ? '0 : ram_dout;
            assign rsp_valid[gi] = (st_reg != ST_IDLE);
            assign rsp_err[gi]   = rsp_valid[gi] & err_reg;
            assign rsp_data[gi]  = (st_reg == ST_WAIT) ? wait_data :
                                   (st_reg == ST_HOLD) ? skid_reg  : '0;
        end
    endgenerate

    assign f_rsp_valid = rsp_valid[CH_FETCH];
    assign f_rsp_data  = rsp_data[CH_FETCH];
    assign f_rsp_err   = rsp_err[CH_FETCH];
    assign l_rsp_valid = rsp_valid[CH_LOAD];
    assign l_rsp_data  = rsp_data[CH_LOAD];
    assign l_rsp_err   = rsp_err[CH_LOAD];

endmodule
